// File: rtl/fb_arbiter_pkg.sv
// Types and constants shared by the framebuffer arbiter, the CPU and the LCD reader.
package fb_arbiter_pkg;

  localparam int         FB_BYTES_DEF  = 256;
  localparam logic [7:0] CLS_VALUE_DEF = 8'h00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // Who owns the RAM read that is returning this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LCD  = 2'd1,
    OWN_CPU  = 2'd2
  } fb_owner_e;

endpackage

// File: rtl/fb_clear_seq.sv
// CLS sequencer: writes one byte per cycle over the whole framebuffer after a start pulse.
// Busy from the cycle after start for FB_BYTES cycles, then a one-cycle done; start while busy is ignored.
module fb_clear_seq
  import fb_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int FB_BYTES = FB_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

  fb_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wr_en_o   = (state_q == ST_CLEAR);
  assign wr_addr_o = cnt_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM owner: LCD reader vs CPU (round-robin on ties) plus the CLS clear.
// Grants are combinational in the request cycle; read data returns one cycle later; CLEAR stalls both requesters.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 8,
  parameter int                FB_BYTES  = FB_BYTES_DEF,
  parameter logic [DATA_W-1:0] CLS_VALUE = DATA_W'(CLS_VALUE_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_req,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic              lcd_gnt,
  output logic [DATA_W-1:0] lcd_data,
  output logic              lcd_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              cls_start,
  output logic              cls_busy,
  output logic              cls_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] FB_LIM = (ADDR_W+1)'(FB_BYTES);

  logic              live_q, live_d;
  fb_owner_e         last_q, last_d;
  fb_owner_e         rd_own_q, rd_own_d;
  logic              rd_oor_q, rd_oor_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              lcd_oor, cpu_oor, gnt_ok;
  logic [DATA_W-1:0] rd_val;

  fb_clear_seq #(
    .ADDR_W   (ADDR_W),
    .FB_BYTES (FB_BYTES)
  ) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (cls_start),
    .busy_o    (cls_busy),
    .done_o    (cls_done),
    .wr_en_o   (clr_we),
    .wr_addr_o (clr_addr)
  );

  assign lcd_oor = ({1'b0, lcd_addr} >= FB_LIM);
  assign cpu_oor = ({1'b0, cpu_addr} >= FB_LIM);
  // live_q keeps grants (and hence RAM strobes) quiet until the first edge after reset release.
  assign gnt_ok  = live_q && !cls_busy && !cls_start;

  always_comb begin
    lcd_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (gnt_ok) begin
      if (lcd_req && cpu_req) begin
        if (last_q == OWN_LCD) cpu_gnt = 1'b1;
        else                   lcd_gnt = 1'b1;
      end else begin
        lcd_gnt = lcd_req;
        cpu_gnt = cpu_req;
      end
    end
  end

  always_comb begin
    ram_addr  = ram_addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (clr_we) begin
      ram_addr  = clr_addr;
      ram_we    = 1'b1;
      ram_wdata = CLS_VALUE;
    end else if (lcd_gnt) begin
      ram_addr = lcd_addr;
    end else if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we && !cpu_oor;
      ram_wdata = cpu_wdata;
    end
  end

  always_comb begin
    live_d     = 1'b1;
    ram_addr_d = ram_addr;
    last_d     = last_q;
    rd_own_d   = OWN_NONE;
    rd_oor_d   = 1'b0;
    if (lcd_gnt) begin
      last_d   = OWN_LCD;
      rd_own_d = OWN_LCD;
      rd_oor_d = lcd_oor;
    end else if (cpu_gnt) begin
      last_d = OWN_CPU;
      if (!cpu_we) begin
        rd_own_d = OWN_CPU;
        rd_oor_d = cpu_oor;
      end
    end
  end

  // Returning data is presented straight from the RAM in its valid cycle, then held in the owner's register.
  always_comb begin
    rd_val      = rd_oor_q ? '0 : ram_rdata;
    lcd_valid   = (rd_own_q == OWN_LCD);
    cpu_rvalid  = (rd_own_q == OWN_CPU);
    lcd_data    = lcd_valid  ? rd_val : lcd_data_q;
    cpu_rdata   = cpu_rvalid ? rd_val : cpu_rdata_q;
    lcd_data_d  = lcd_data;
    cpu_rdata_d = cpu_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      last_q      <= OWN_CPU;
      rd_own_q    <= OWN_NONE;
      rd_oor_q    <= 1'b0;
      ram_addr_q  <= '0;
      lcd_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      live_q      <= live_d;
      last_q      <= last_d;
      rd_own_q    <= rd_own_d;
      rd_oor_q    <= rd_oor_d;
      ram_addr_q  <= ram_addr_d;
      lcd_data_q  <= lcd_data_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: bench-side RAM, requester tasks push expected returns, a monitor pops and checks them.
module tb_fb_arbiter;

  localparam int BOUND = 600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_req, lcd_gnt, lcd_valid;
  logic [9:0] lcd_addr;
  logic [7:0] lcd_data;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cls_start, cls_busy, cls_done;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cyc = -1;

  logic [7:0]  mem [0:1023];
  logic [1:0]  bd_mode = 2'd0;
  logic [39:0] lcd_q[$];
  logic [39:0] cpu_q[$];
  logic [7:0]  gnt_log[$];
  int          gnt_cyc[$];

  fb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_req    (lcd_req),
    .lcd_addr   (lcd_addr),
    .lcd_gnt    (lcd_gnt),
    .lcd_data   (lcd_data),
    .lcd_valid  (lcd_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cls_start  (cls_start),
    .cls_busy   (cls_busy),
    .cls_done   (cls_done),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM; bd_mode 1 preloads 8'hA0+addr (addr 300 = 8'h55), bd_mode 2 fills 0..255 with 8'hFF.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (bd_mode == 2'd1) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i < 256) ? 8'(8'hA0 + i) : ((i == 300) ? 8'h55 : 8'h00);
    end else if (bd_mode == 2'd2) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [39:0] ent;
    if (lcd_valid) begin
      if (lcd_q.size() == 0) chk("lcd_valid_unexpected", 64'd1, 64'd0);
      else begin
        ent = lcd_q.pop_front();
        chk("lcd_data", 64'(lcd_data), 64'(ent[7:0]));
        chk("lcd_latency", 64'(cyc), 64'(ent[39:8]));
      end
    end
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 64'd1, 64'd0);
      else begin
        ent = cpu_q.pop_front();
        chk("cpu_rdata", 64'(cpu_rdata), 64'(ent[7:0]));
        chk("cpu_latency", 64'(cyc), 64'(ent[39:8]));
      end
    end
    if (lcd_gnt || cpu_gnt) begin
      gnt_log.push_back(lcd_gnt ? 8'h4C : 8'h43);
      gnt_cyc.push_back(cyc);
      chk("single_grant", 64'(lcd_gnt & cpu_gnt), 64'd0);
      chk("grant_while_busy", 64'(cls_busy), 64'd0);
    end
  end

  task automatic backdoor(input logic [1:0] mode);
    bd_mode = mode;
    @(posedge clk); #1;
    bd_mode = 2'd0;
  endtask

  task automatic lcd_read(input logic [9:0] a, input logic [7:0] e);
    bit got = 1'b0;
    lcd_req = 1'b1; lcd_addr = a;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (lcd_gnt) begin got = 1'b1; lcd_q.push_back({32'(cyc + 1), e}); break; end
    end
    if (!got) chk("lcd_grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    lcd_req = 1'b0;
  endtask

  task automatic cpu_read(input logic [9:0] a, input logic [7:0] e);
    bit got = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin got = 1'b1; cpu_q.push_back({32'(cyc + 1), e}); break; end
    end
    if (!got) chk("cpu_grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d, input logic exp_we);
    bit got = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin
        got = 1'b1;
        chk("wr_ram_we", 64'(ram_we), 64'(exp_we));
        chk("wr_ram_addr", 64'(ram_addr), 64'(a));
        break;
      end
    end
    if (!got) chk("cpu_write_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic run_clear(input bit inject);
    int busy_n = 0;
    int done_n = 0;
    int bad = 0;
    int done_i = -1;
    logic [9:0] ea = '0;
    cls_start = 1'b1;
    @(posedge clk); #1;
    cls_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cls_busy) begin
        busy_n++;
        if (!(ram_we && ram_addr == ea && ram_wdata == 8'h00)) bad++;
        ea = ea + 10'd1;
      end
      if (cls_done) begin done_n++; done_i = i; done_cyc = cyc; end
      cls_start = inject && (busy_n == 50);
      if (done_n > 0 && i >= done_i + 4) break;
    end
    cls_start = 1'b0;
    chk("clr_busy_cycles", 64'(busy_n), 64'd256);
    chk("clr_done_count", 64'(done_n), 64'd1);
    chk("clr_done_index", 64'(done_i), 64'd256);
    chk("clr_write_errors", 64'(bad), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] seq_act;
    logic [47:0] seq_exp;
    int nz;
    rst_n = 1'b0; lcd_req = 1'b0; lcd_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cls_start = 1'b0;
    repeat (2) @(posedge clk); #1;
    backdoor(2'd1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Some traffic so reset has held state to clear.
    lcd_read(10'd8, 8'hA8);
    cpu_read(10'd9, 8'hA9);
    @(posedge clk); #1;
    chk("hold_lcd_data", 64'(lcd_data), 64'hA8);
    chk("hold_cpu_rdata", 64'(cpu_rdata), 64'hA9);
    chk("hold_ram_addr", 64'(ram_addr), 64'd9);

    lcd_req = 1'b1; lcd_addr = 10'd5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd10;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", 64'({lcd_gnt, lcd_valid, lcd_data, cpu_gnt, cpu_rvalid, cpu_rdata,
                              cls_busy, cls_done, ram_we, ram_addr, ram_wdata}), 64'd0);
    gnt_log.delete(); gnt_cyc.delete();

    // Release with both requesting: LCD first, then strict alternation.
    fork
      begin repeat (2) @(posedge clk); #1; rst_n = 1'b1; end
      begin lcd_read(10'd5, 8'hA5); lcd_read(10'd6, 8'hA6); lcd_read(10'd7, 8'hA7); end
      begin cpu_read(10'd10, 8'hAA); cpu_read(10'd11, 8'hAB); cpu_read(10'd12, 8'hAC); end
    join
    @(posedge clk); #1;
    seq_exp = "LCLCLC";
    seq_act = '0;
    foreach (gnt_log[i]) if (i < 6) seq_act[8*(5-i) +: 8] = gnt_log[i];
    chk("grant_count", 64'(gnt_log.size()), 64'd6);
    chk("grant_order", 64'(seq_act), 64'(seq_exp));
    if (gnt_cyc.size() == 6) chk("grant_back_to_back", 64'(gnt_cyc[5] - gnt_cyc[0]), 64'd5);

    // CPU write then LCD read back.
    cpu_write(10'd17, 8'h3C, 1'b1);
    @(negedge clk);
    chk("wr_we_one_cycle", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    lcd_read(10'd17, 8'h3C);
    @(posedge clk); #1;

    // Out-of-range accesses.
    cpu_write(10'd300, 8'hFF, 1'b0);
    chk("oor_ram_unchanged", 64'(mem[300]), 64'h55);
    lcd_read(10'd300, 8'h00);
    cpu_read(10'd300, 8'h00);
    @(negedge clk);
    chk("idle_addr_held", 64'(ram_addr), 64'd300);
    chk("idle_we_low", 64'(ram_we), 64'd0);
    @(posedge clk); #1;

    // Full clear with a CPU read waiting across it.
    backdoor(2'd2);
    gnt_log.delete(); gnt_cyc.delete();
    fork
      run_clear(1'b1);
      begin repeat (3) @(posedge clk); #1; cpu_read(10'd40, 8'h00); end
    join
    chk("clr_cpu_grant_count", 64'(gnt_cyc.size()), 64'd1);
    if (gnt_cyc.size() > 0) chk("clr_cpu_grant_cycle", 64'(gnt_cyc[0]), 64'(done_cyc));
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'h00) nz++;
    chk("clr_all_zero", 64'(nz), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a clear.
    backdoor(2'd2);
    cls_start = 1'b1;
    @(posedge clk); #1;
    cls_start = 1'b0;
    nz = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 10'd100) begin nz = 1; break; end
    end
    chk("abort_reached_100", 64'(nz), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy_low", 64'(cls_busy), 64'd0);
    nz = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (cls_done) nz++; end
    chk("abort_no_done", 64'(nz), 64'd0);
    nz = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== 8'h00) nz++;
    chk("abort_low_cleared", 64'(nz), 64'd0);
    nz = 0;
    for (int i = 100; i < 256; i++) if (mem[i] !== 8'hFF) nz++;
    chk("abort_high_kept", 64'(nz), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    run_clear(1'b0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'h00) nz++;
    chk("reclear_all_zero", 64'(nz), 64'd0);

    repeat (3) @(posedge clk); #1;
    chk("lcd_queue_drained", 64'(lcd_q.size()), 64'd0);
    chk("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
